// File: rtl/conv_encoder.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder
// Brief    : Rate-1/2, K=3 convolutional encoder framer. Serializes one message
//            MSB-first and appends two zero tail bits, so every frame ends in state 00.
// Revision : 1.0
// ============================================================================
module conv_encoder #(
  parameter int         data_width = 2,
  parameter int         seq_width  = 10,
  parameter logic [2:0] G0         = 3'b111,
  parameter logic [2:0] G1         = 3'b101
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  msg_valid,
  input  logic [seq_width-1:0]  msg_data,
  output logic                  msg_ready,
  output logic [data_width-1:0] sym_out,
  output logic                  sym_valid,
  input  logic                  sym_ready,
  output logic                  sym_last,
  output logic                  busy,
  output logic [1:0]            enc_state
);

  localparam int c_cnt_w = $clog2(seq_width + 2);
  localparam logic [c_cnt_w-1:0] c_last_data = c_cnt_w'(seq_width - 1);
  localparam logic [c_cnt_w-1:0] c_last_tail = c_cnt_w'(seq_width + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_TAIL   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [seq_width-1:0] r_msg;
  logic [1:0]           r_enc;
  logic [c_cnt_w-1:0]   r_cnt;

  logic       w_active;
  logic       w_u;
  logic       w_shift;
  logic [2:0] w_taps;

  assign w_active = (r_state == S_ENCODE) || (r_state == S_TAIL);
  // Tail symbols feed zeros to flush the register back to 00.
  assign w_u      = (r_state == S_ENCODE) ? r_msg[seq_width-1] : 1'b0;
  assign w_taps   = {w_u, r_enc};
  assign w_shift  = w_active && sym_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (msg_valid) w_state_next = S_ENCODE;
      S_ENCODE: if (sym_ready && (r_cnt == c_last_data)) w_state_next = S_TAIL;
      S_TAIL:   if (sym_ready && (r_cnt == c_last_tail)) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_msg   <= '0;
      r_enc   <= 2'b00;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == S_IDLE) && msg_valid) begin
        r_msg <= msg_data;
        r_enc <= 2'b00;
        r_cnt <= '0;
      end else if (w_shift) begin
        r_enc <= {w_u, r_enc[1]};
        r_msg <= r_msg << 1;
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
    end
  end

  assign sym_out   = w_active ? {^(w_taps & G0), ^(w_taps & G1)} : '0;
  assign sym_valid = w_active;
  assign sym_last  = (r_state == S_TAIL) && (r_cnt == c_last_tail);
  assign msg_ready = (r_state == S_IDLE);
  assign busy      = w_active;
  assign enc_state = r_enc;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder
// Brief    : Self-checking bench for conv_encoder: fixed vector table, random frames
//            against a bit-level reference model, reset and collision sequences.
// Revision : 1.0
// ============================================================================
module tb_conv_encoder;

  localparam int W  = 10;
  localparam int NS = W + 2;
  localparam logic [2:0] P0 = 3'b111;
  localparam logic [2:0] P1 = 3'b101;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          msg_valid = 1'b0;
  logic [W-1:0]  msg_data = '0;
  logic          msg_ready;
  logic [1:0]    sym_out;
  logic          sym_valid;
  logic          sym_ready = 1'b1;
  logic          sym_last;
  logic          busy;
  logic [1:0]    enc_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_encoder #(
    .data_width(2),
    .seq_width (W),
    .G0        (P0),
    .G1        (P1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .msg_valid(msg_valid),
    .msg_data (msg_data),
    .msg_ready(msg_ready),
    .sym_out  (sym_out),
    .sym_valid(sym_valid),
    .sym_ready(sym_ready),
    .sym_last (sym_last),
    .busy     (busy),
    .enc_state(enc_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Input bit fed to the encoder at symbol index i (tail and pre-frame bits are 0).
  function automatic int u_at(input logic [W-1:0] msg, input int i);
    if (i < 0 || i >= W) return 0;
    return int'(msg[W-1-i]);
  endfunction

  function automatic int parity3(input logic [2:0] g, input int u, input int a, input int b);
    return (u * int'(g[2]) + a * int'(g[1]) + b * int'(g[0])) % 2;
  endfunction

  function automatic logic [2*NS-1:0] model_stream(input logic [W-1:0] msg);
    logic [2*NS-1:0] s;
    s = '0;
    for (int i = 0; i < NS; i++) begin
      s[2*NS-1-2*i]   = parity3(P0, u_at(msg, i), u_at(msg, i-1), u_at(msg, i-2)) != 0;
      s[2*NS-2-2*i]   = parity3(P1, u_at(msg, i), u_at(msg, i-1), u_at(msg, i-2)) != 0;
    end
    return s;
  endfunction

  // Called just after a negedge with the DUT idle; returns just after the negedge
  // where the DUT is idle again. mode: 0 ready always, 1 alternating (low first), 2 random.
  task automatic run_frame(input logic [W-1:0] msg, input logic [2*NS-1:0] exp,
                           input int mode, input bit collide, input logic [W-1:0] next_msg);
    int k;
    int cyc;
    bit rdy;
    logic [1:0] es;
    chk("idle_msg_ready", 32'(msg_ready), 1);
    msg_valid = 1'b1;
    msg_data  = msg;
    @(posedge clk);
    @(negedge clk);
    msg_valid = collide;
    msg_data  = collide ? next_msg : msg;
    k = 0;
    cyc = 0;
    while (k < NS && cyc < 4 * NS + 50) begin
      es = {u_at(msg, k-1) != 0, u_at(msg, k-2) != 0};
      chk("sym_valid", 32'(sym_valid), 1);
      chk("busy", 32'(busy), 1);
      chk("msg_ready_in_frame", 32'(msg_ready), 0);
      chk($sformatf("sym_out[%0d]", k), 32'(sym_out), 32'(exp[2*NS-1-2*k -: 2]));
      chk($sformatf("sym_last[%0d]", k), 32'(sym_last), 32'(k == NS-1));
      chk($sformatf("enc_state[%0d]", k), 32'(enc_state), 32'(es));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = cyc[0];
        default: rdy = 1'($urandom_range(1, 0));
      endcase
      sym_ready = rdy;
      @(posedge clk);
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    sym_ready = 1'b1;
    chk("frame_timeout", 32'(k), 32'(NS));
    chk("end_msg_ready", 32'(msg_ready), 1);
    chk("end_sym_valid", 32'(sym_valid), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_sym_last", 32'(sym_last), 0);
    chk("end_sym_out", 32'(sym_out), 0);
    chk("end_enc_state", 32'(enc_state), 0);
    if (mode == 0) chk("frame_cycles", 32'(cyc), 32'(NS));
    if (mode == 1) chk("frame_cycles_bp", 32'(cyc), 32'(2 * NS));
  endtask

  typedef struct {
    logic [W-1:0]    msg;
    logic [2*NS-1:0] syms;
    int              mode;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [W-1:0] m, m2;
    tbl[0] = '{msg: 10'b1011000000, syms: 24'b11_10_00_01_01_11_00_00_00_00_00_00, mode: 0};
    tbl[1] = '{msg: 10'h3FF,        syms: 24'b11_01_10_10_10_10_10_10_10_10_01_11, mode: 0};
    tbl[2] = '{msg: 10'b1011000000, syms: 24'b11_10_00_01_01_11_00_00_00_00_00_00, mode: 1};

    // Reset with message offers that must be ignored.
    repeat (2) @(negedge clk);
    msg_valid = 1'b1;
    msg_data  = 10'h3A5;
    @(negedge clk);
    msg_valid = 1'b0;
    @(negedge clk);
    msg_valid = 1'b1;
    @(negedge clk);
    msg_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_msg_ready", 32'(msg_ready), 1);
    chk("rst_sym_valid", 32'(sym_valid), 0);
    chk("rst_sym_last", 32'(sym_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sym_out", 32'(sym_out), 0);
    chk("rst_enc_state", 32'(enc_state), 0);

    for (int i = 0; i < 3; i++)
      run_frame(tbl[i].msg, tbl[i].syms, tbl[i].mode, 1'b0, '0);

    // Collision: second message offered during the whole first frame.
    run_frame(10'b1100110101, model_stream(10'b1100110101), 0, 1'b1, 10'b0111001011);
    run_frame(10'b0111001011, model_stream(10'b0111001011), 2, 1'b0, '0);

    // Reset mid-frame after symbol 5, asserted between clock edges.
    msg_valid = 1'b1;
    msg_data  = 10'b1011000000;
    @(posedge clk);
    @(negedge clk);
    msg_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_msg_ready", 32'(msg_ready), 1);
    chk("async_rst_sym_valid", 32'(sym_valid), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_sym_out", 32'(sym_out), 0);
    chk("async_rst_enc_state", 32'(enc_state), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_frame(tbl[1].msg, tbl[1].syms, 0, 1'b0, '0);

    // Random frames against the model with random backpressure.
    for (int i = 0; i < 8; i++) begin
      m  = W'($urandom);
      m2 = W'($urandom);
      run_frame(m, model_stream(m), 2, 1'b0, m2);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
